// File: rtl/frame_write_ctrl_pkg.sv
// frame_write_ctrl_pkg: FSM states and default frame-buffer geometry shared by the
// write-side and read-side frame controllers.
package frame_write_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ACK, WAIT_DATA, CMD, WAIT_DONE, DONE} state_t;
  localparam int DEF_FRAME_WORDS = 196608;
  localparam int DEF_BASE_ADDR0 = 0;
  localparam int DEF_BASE_ADDR1 = 'h0040000;
endpackage

// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl: splits each captured frame into memory write bursts and
// ping-pongs between two frame buffers.
module frame_write_ctrl
  import frame_write_ctrl_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int LEN_W = 10,
  parameter int BURST_LEN = 128,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int BASE_ADDR0 = DEF_BASE_ADDR0,
  parameter int BASE_ADDR1 = DEF_BASE_ADDR1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_req,
  output logic              write_req_ack,
  input  logic [LEN_W:0]    fifo_rd_count,
  output logic              burst_cmd_valid,
  input  logic              burst_cmd_ready,
  output logic [ADDR_W-1:0] burst_cmd_addr,
  output logic [LEN_W-1:0]  burst_cmd_len,
  input  logic              burst_done,
  output logic              write_busy,
  output logic              frame_done,
  output logic              frame_index
);
  // remaining is kept wider than the length field so the zero-extension below is always legal
  localparam int RW_MIN = $clog2(FRAME_WORDS + 1);
  localparam int RW = RW_MIN > LEN_W ? RW_MIN : LEN_W + 1;
  state_t state, state_nxt;
  logic [RW-1:0] rem, rem_src;
  logic [LEN_W-1:0] len_nxt;
  logic accept;
  always_comb begin
    accept = state == CMD && burst_cmd_ready;
    rem_src = state == ACK ? RW'(FRAME_WORDS) : rem - {{(RW-LEN_W){1'b0}}, burst_cmd_len};
    len_nxt = rem_src >= RW'(BURST_LEN) ? LEN_W'(BURST_LEN) : rem_src[LEN_W-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (write_req) state_nxt = ACK;
      ACK:       state_nxt = WAIT_DATA;
      WAIT_DATA: if (fifo_rd_count >= {1'b0, burst_cmd_len}) state_nxt = CMD;
      CMD:       if (burst_cmd_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (burst_done) state_nxt = rem != '0 ? WAIT_DATA : DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    write_req_ack = state == ACK;
    burst_cmd_valid = state == CMD;
    write_busy = state != IDLE && state != DONE;
    frame_done = state == DONE;
  end
  // frame_index flips on entry to DONE so it already names the new buffer during frame_done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      burst_cmd_addr <= '0;
      burst_cmd_len <= '0;
      rem <= '0;
      frame_index <= 1'b1;
    end else begin
      if (state == ACK || accept) begin
        burst_cmd_len <= len_nxt;
        rem <= rem_src;
      end
      if (state == ACK) burst_cmd_addr <= frame_index ? ADDR_W'(BASE_ADDR0) : ADDR_W'(BASE_ADDR1);
      else if (accept) burst_cmd_addr <= burst_cmd_addr + ADDR_W'(burst_cmd_len);
      if (state == WAIT_DONE && burst_done && rem == '0) frame_index <= ~frame_index;
    end
endmodule

// File: tb/tb_frame_write_ctrl.sv
// tb_frame_write_ctrl: two controllers (256- and 300-word frames) checked every cycle
// against a burst-level model, plus hand-computed command pins.
module tb_frame_write_ctrl;
  localparam int AW = 25, LW = 10, BL = 128, B1 = 'h40000;
  logic clk = 0, rst;
  logic write_req [2], burst_cmd_ready [2], burst_done [2];
  logic [LW:0] fifo_rd_count [2];
  logic write_req_ack [2], burst_cmd_valid [2], write_busy [2], frame_done [2], frame_index [2];
  logic [AW-1:0] burst_cmd_addr [2];
  logic [LW-1:0] burst_cmd_len [2];
  frame_write_ctrl #(.ADDR_W(AW), .LEN_W(LW), .BURST_LEN(BL), .FRAME_WORDS(256)) u0 (
    .clk(clk), .rst(rst), .write_req(write_req[0]), .write_req_ack(write_req_ack[0]),
    .fifo_rd_count(fifo_rd_count[0]), .burst_cmd_valid(burst_cmd_valid[0]),
    .burst_cmd_ready(burst_cmd_ready[0]), .burst_cmd_addr(burst_cmd_addr[0]),
    .burst_cmd_len(burst_cmd_len[0]), .burst_done(burst_done[0]), .write_busy(write_busy[0]),
    .frame_done(frame_done[0]), .frame_index(frame_index[0]));
  frame_write_ctrl #(.ADDR_W(AW), .LEN_W(LW), .BURST_LEN(BL), .FRAME_WORDS(300)) u1 (
    .clk(clk), .rst(rst), .write_req(write_req[1]), .write_req_ack(write_req_ack[1]),
    .fifo_rd_count(fifo_rd_count[1]), .burst_cmd_valid(burst_cmd_valid[1]),
    .burst_cmd_ready(burst_cmd_ready[1]), .burst_cmd_addr(burst_cmd_addr[1]),
    .burst_cmd_len(burst_cmd_len[1]), .burst_done(burst_done[1]), .write_busy(write_busy[1]),
    .frame_done(frame_done[1]), .frame_index(frame_index[1]));
  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // model: one frame = an ack, then per burst "wait for data, present command, wait for completion"
  typedef struct {int inst; int addr; int len;} cmd_t;
  cmd_t log_q[$];
  bit m_ack [2], m_wait [2], m_cmd [2], m_out [2], m_done [2], m_idx [2];
  int m_addr [2], m_rem [2];
  function automatic int fw(input int i); return i ? 300 : 256; endfunction
  function automatic int mlen(input int i); return m_rem[i] < BL ? m_rem[i] : BL; endfunction
  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_ack[i] = 0; m_wait[i] = 0; m_cmd[i] = 0; m_out[i] = 0; m_done[i] = 0;
      m_idx[i] = 1; m_addr[i] = 0; m_rem[i] = 0;
    end
  endtask
  task automatic mstep();
    int l;
    if (rst) begin mreset(); return; end
    for (int i = 0; i < 2; i++) begin
      l = mlen(i);
      if (m_ack[i]) begin
        m_ack[i] = 0; m_wait[i] = 1; m_rem[i] = fw(i); m_addr[i] = m_idx[i] ? 0 : B1;
      end else if (m_wait[i]) begin
        if (int'(fifo_rd_count[i]) >= l) begin m_wait[i] = 0; m_cmd[i] = 1; end
      end else if (m_cmd[i]) begin
        if (burst_cmd_ready[i]) begin
          log_q.push_back(cmd_t'{i, m_addr[i], l});
          m_cmd[i] = 0; m_out[i] = 1; m_addr[i] += l; m_rem[i] -= l;
        end
      end else if (m_out[i]) begin
        if (burst_done[i]) begin
          m_out[i] = 0;
          if (m_rem[i] != 0) m_wait[i] = 1;
          else begin m_done[i] = 1; m_idx[i] = !m_idx[i]; end
        end
      end else if (m_done[i]) m_done[i] = 0;
      else if (write_req[i]) m_ack[i] = 1;
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk("ack", i, write_req_ack[i], m_ack[i]);
      chk("valid", i, burst_cmd_valid[i], m_cmd[i]);
      chk("busy", i, write_busy[i], m_ack[i] | m_wait[i] | m_cmd[i] | m_out[i]);
      chk("frame_done", i, frame_done[i], m_done[i]);
      chk("frame_index", i, frame_index[i], m_idx[i]);
      if (m_cmd[i]) begin
        chk("addr", i, burst_cmd_addr[i], m_addr[i]);
        chk("len", i, burst_cmd_len[i], mlen(i));
      end
    end

  // memory-controller stand-in: ready after rdy_delay cycles of valid, done done_lat cycles after accept
  int rdy_delay [2] = '{0, 0}, done_lat [2] = '{1, 1}, vcnt [2] = '{0, 0}, dcnt [2] = '{0, 0};
  task automatic tick();
    bit hs [2];
    for (int i = 0; i < 2; i++) hs[i] = burst_cmd_valid[i] && burst_cmd_ready[i];
    @(posedge clk);
    mstep();
    #2;
    for (int i = 0; i < 2; i++) begin
      burst_done[i] = 0;
      if (dcnt[i] > 0) begin dcnt[i]--; if (dcnt[i] == 0) burst_done[i] = 1; end
      if (hs[i]) dcnt[i] = done_lat[i];
      vcnt[i] = burst_cmd_valid[i] ? vcnt[i] + 1 : 0;
      burst_cmd_ready[i] = vcnt[i] > rdy_delay[i];
    end
  endtask
  task automatic wait_fd(input int i);
    int n = 0;
    while (!frame_done[i] && n < 3000) begin tick(); n++; end
    chk("frame_done_reached", i, frame_done[i], 1);
  endtask
  task automatic start_frame(input int i);
    write_req[i] = 1;
    tick();
    chk("ack_one_cycle_after_req", i, write_req_ack[i], 1);
    write_req[i] = 0;
  endtask
  function automatic int ncmd(input int i);
    int c = 0;
    foreach (log_q[j]) if (log_q[j].inst == i) c++;
    return c;
  endfunction
  task automatic pin(input int i, input int k, input int a, input int l);
    int c = 0;
    cmd_t f = '{i, -1, -1};
    foreach (log_q[j]) if (log_q[j].inst == i) begin
      if (c == k) f = log_q[j];
      c++;
    end
    chk($sformatf("cmd%0d_addr", k), i, f.addr, a);
    chk($sformatf("cmd%0d_len", k), i, f.len, l);
  endtask

  initial begin
    bit seen;
    int n;
    mreset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      write_req[i] = 0; burst_cmd_ready[i] = 0; burst_done[i] = 0; fifo_rd_count[i] = 512;
    end
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", i, write_req_ack[i], 0);
      chk("rst_valid", i, burst_cmd_valid[i], 0);
      chk("rst_busy", i, write_busy[i], 0);
      chk("rst_done", i, frame_done[i], 0);
      chk("rst_addr", i, burst_cmd_addr[i], 0);
      chk("rst_len", i, burst_cmd_len[i], 0);
      chk("rst_index", i, frame_index[i], 1);
    end
    rst = 0;
    tick();
    start_frame(0); wait_fd(0); tick(); chk("index_f1", 0, frame_index[0], 0);
    start_frame(0); wait_fd(0); tick(); chk("index_f2", 0, frame_index[0], 1);
    start_frame(0); wait_fd(0); tick(); chk("index_f3", 0, frame_index[0], 0);
    pin(0, 0, 0, 128); pin(0, 1, 'h80, 128);
    pin(0, 2, B1, 128); pin(0, 3, B1 + 'h80, 128);
    pin(0, 4, 0, 128);
    chk("cmd_count_256", 0, ncmd(0), 6);
    start_frame(1); wait_fd(1);
    repeat (20) tick();
    chk("cmd_count_300", 1, ncmd(1), 3);
    pin(1, 0, 0, 128); pin(1, 1, 'h80, 128); pin(1, 2, 'h100, 44);
    fifo_rd_count[1] = 100; rdy_delay[1] = 5;
    start_frame(1);
    repeat (10) begin tick(); chk("stall_valid", 1, burst_cmd_valid[1], 0); end
    fifo_rd_count[1] = 128;
    tick();
    chk("fill_valid", 1, burst_cmd_valid[1], 1);
    repeat (4) tick();
    chk("held_valid", 1, burst_cmd_valid[1], 1);
    chk("held_addr", 1, burst_cmd_addr[1], B1);
    chk("held_len", 1, burst_cmd_len[1], 128);
    fifo_rd_count[1] = 512;
    wait_fd(1); tick();
    chk("index_f2_300", 1, frame_index[1], 1);
    pin(1, 3, B1, 128); pin(1, 5, B1 + 'h100, 44);
    rdy_delay[1] = 0;
    write_req[0] = 1;
    tick();
    chk("busy_req_ack", 0, write_req_ack[0], 1);
    wait_fd(0);
    chk("req_in_done", 0, write_req_ack[0], 0);
    tick(); chk("req_in_idle", 0, write_req_ack[0], 0);
    tick(); chk("req_two_after_done", 0, write_req_ack[0], 1);
    write_req[0] = 0;
    done_lat[0] = 6;
    n = 0;
    while (!burst_cmd_valid[0] && n < 100) begin tick(); n++; end
    chk("cmd_before_rst", 0, burst_cmd_valid[0], 1);
    tick();
    chk("in_wait_done_busy", 0, write_busy[0], 1);
    rst = 1;
    mreset();
    #1;
    chk("arst_busy", 0, write_busy[0], 0);
    chk("arst_valid", 0, burst_cmd_valid[0], 0);
    chk("arst_addr", 0, burst_cmd_addr[0], 0);
    chk("arst_len", 0, burst_cmd_len[0], 0);
    chk("arst_index", 0, frame_index[0], 1);
    tick();
    rst = 0;
    seen = 0;
    repeat (12) begin tick(); if (frame_done[0]) seen = 1; end
    chk("no_done_after_rst", 0, seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
